// File: rtl/decode_stage.sv
// decode_stage
// ------------
// Registered RV32I/RV32E decode stage sitting between fetch and
// register-read/execute. Each instruction taken from fetch is decoded and
// captured into output registers. The captured bundle stays bit-stable
// until downstream takes it.
//
// Parameters:
//   PC_W        - width of the program counter carried with the instruction
//   RV32E       - 1 flags any used register index >= 16 as illegal
//   FENCE_LEGAL - 1 decodes MISC-MEM (FENCE) as a legal no-op, 0 traps it
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   in_valid / in_ready   - fetch-side handshake
//   in_instr, in_pc       - raw instruction word and its address
//   flush                 - drops the held bundle and the offered instruction
//   out_valid / out_ready - execute-side handshake
//   out_pc                - registered PC
//   out_class             - one-hot {FENCE, SYSTEM, STORE, LOAD, LUI, AUIPC,
//                           JAL, JALR, BRANCH, ALUIMM, ALUREG}, MSB first
//   out_rs1/rs2/rd        - raw register index fields
//   out_funct3/funct7     - raw function fields
//   out_imm               - sign-extended immediate for the instruction format
//   out_rs1_used/rs2_used - operand read flags for hazard detection
//   out_rd_we             - instruction writes a non-zero destination
//   out_illegal           - instruction must trap further down the pipe

module decode_stage #(
    parameter int PC_W        = 32,
    parameter bit RV32E       = 1'b0,
    parameter bit FENCE_LEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [10:0]     out_class,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [31:0]     out_imm,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_we,
    output logic            out_illegal
);

    // Bit positions inside the one-hot class vector.
    localparam int C_ALUREG = 0;
    localparam int C_ALUIMM = 1;
    localparam int C_BRANCH = 2;
    localparam int C_JALR   = 3;
    localparam int C_JAL    = 4;
    localparam int C_AUIPC  = 5;
    localparam int C_LUI    = 6;
    localparam int C_LOAD   = 7;
    localparam int C_STORE  = 8;
    localparam int C_SYSTEM = 9;
    localparam int C_FENCE  = 10;

    // Major opcodes (full seven bits, so the mandatory "11" suffix is
    // part of every match).
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Raw instruction fields; these are passed through unchanged whatever
    // the format, so downstream sees exactly what was fetched.
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    // Opcode matches before any legality screening.
    logic is_alureg, is_aluimm, is_branch, is_jalr, is_jal, is_auipc;
    logic is_lui, is_load, is_store, is_system, is_fence;

    assign is_alureg = (opcode == OP_ALUREG);
    assign is_aluimm = (opcode == OP_ALUIMM);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_jal    = (opcode == OP_JAL);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_lui    = (opcode == OP_LUI);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_system = (opcode == OP_SYSTEM);
    assign is_fence  = (opcode == OP_FENCE) && FENCE_LEGAL;

    // Sign-extended immediates for every format; the class picks one.
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    logic [10:0] raw_class;
    logic        raw_rs1_used, raw_rs2_used, raw_rd_we;
    logic        funct_bad, rv32e_bad, legal;
    logic [10:0] dec_class;
    logic        dec_rs1_used, dec_rs2_used, dec_rd_we;
    logic [31:0] dec_imm;

    // Classify the offered word and screen it for illegal encodings. The
    // operand/writeback flags are first worked out from the opcode alone
    // because the RV32E register limit only applies to indices that are
    // actually read or written; once legality is known, an illegal word
    // has every class and operand flag forced to zero so nothing
    // downstream acts on it except the trap.
    always_comb begin
        raw_class = '0;
        raw_class[C_ALUREG] = is_alureg;
        raw_class[C_ALUIMM] = is_aluimm;
        raw_class[C_BRANCH] = is_branch;
        raw_class[C_JALR]   = is_jalr;
        raw_class[C_JAL]    = is_jal;
        raw_class[C_AUIPC]  = is_auipc;
        raw_class[C_LUI]    = is_lui;
        raw_class[C_LOAD]   = is_load;
        raw_class[C_STORE]  = is_store;
        raw_class[C_SYSTEM] = is_system;
        raw_class[C_FENCE]  = is_fence;

        raw_rs1_used = is_alureg | is_aluimm | is_branch | is_jalr
                     | is_load | is_store;
        raw_rs2_used = is_alureg | is_branch | is_store;
        raw_rd_we    = (is_alureg | is_aluimm | is_jal | is_jalr | is_lui
                     | is_auipc | is_load | (is_system && funct3 != 3'b000))
                     && (rd != 5'd0);

        funct_bad = 1'b0;
        if (is_alureg && funct7 != F7_ZERO && funct7 != F7_ALT)
            funct_bad = 1'b1;
        if (is_alureg && funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
            funct_bad = 1'b1;
        if (is_aluimm && funct3 == 3'b001 && funct7 != F7_ZERO)
            funct_bad = 1'b1;
        if (is_aluimm && funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT)
            funct_bad = 1'b1;
        if (is_branch && (funct3 == 3'b010 || funct3 == 3'b011))
            funct_bad = 1'b1;
        if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            funct_bad = 1'b1;
        if (is_store && funct3 >= 3'b011)
            funct_bad = 1'b1;
        if (is_jalr && funct3 != 3'b000)
            funct_bad = 1'b1;

        rv32e_bad = RV32E && ((raw_rs1_used && rs1[4])
                           || (raw_rs2_used && rs2[4])
                           || (raw_rd_we && rd[4]));

        legal = (in_instr[1:0] == 2'b11) && (raw_class != 11'd0)
             && !funct_bad && !rv32e_bad;

        dec_class    = legal ? raw_class : 11'd0;
        dec_rs1_used = legal && raw_rs1_used;
        dec_rs2_used = legal && raw_rs2_used;
        dec_rd_we    = legal && raw_rd_we;
    end

    // Pick the immediate from the decoded class. ALUREG and illegal words
    // have no format and carry zero.
    always_comb begin
        dec_imm = 32'd0;
        if (dec_class[C_ALUIMM] | dec_class[C_JALR] | dec_class[C_LOAD]
            | dec_class[C_SYSTEM] | dec_class[C_FENCE])
            dec_imm = imm_i;
        else if (dec_class[C_STORE])
            dec_imm = imm_s;
        else if (dec_class[C_BRANCH])
            dec_imm = imm_b;
        else if (dec_class[C_LUI] | dec_class[C_AUIPC])
            dec_imm = imm_u;
        else if (dec_class[C_JAL])
            dec_imm = imm_j;
    end

    // The stage can take a new word whenever its register is empty or is
    // being drained this cycle. Flush deliberately does not gate this, so
    // fetch sees the same ready it would otherwise and simply has its
    // word dropped.
    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Handshake register. Reset beats flush, flush beats accept, and a
    // drain with no replacement empties the stage. Simultaneous drain and
    // accept just overwrites, which is what gives back-to-back throughput.
    always_ff @(posedge clk) begin
        if (reset)
            out_valid <= 1'b0;
        else if (flush)
            out_valid <= 1'b0;
        else if (accept)
            out_valid <= 1'b1;
        else if (out_ready)
            out_valid <= 1'b0;
    end

    // Payload registers only load on accept, so they stay bit-stable
    // under backpressure and keep their last value after a drain or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pc       <= '0;
            out_class    <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_funct3   <= '0;
            out_funct7   <= '0;
            out_imm      <= '0;
            out_rs1_used <= 1'b0;
            out_rs2_used <= 1'b0;
            out_rd_we    <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (accept) begin
            out_pc       <= in_pc;
            out_class    <= dec_class;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_rd       <= rd;
            out_funct3   <= funct3;
            out_funct7   <= funct7;
            out_imm      <= dec_imm;
            out_rs1_used <= dec_rs1_used;
            out_rs2_used <= dec_rs2_used;
            out_rd_we    <= dec_rd_we;
            out_illegal  <= !legal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// ---------------
// Drives two decode_stage instances from the same stimulus: one with the
// default parameters (RV32I, FENCE legal) and one with RV32E=1 and
// FENCE_LEGAL=0. A directed table covers the known encodings, a few
// hand-written sequences cover backpressure, flush and reset, and a random
// phase compares every output against a behavioural model.

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready0, out_valid0, rs1u0, rs2u0, rdwe0, ill0;
    logic [31:0] pc0, imm0;
    logic [10:0] cls0;
    logic [4:0]  rs1_0, rs2_0, rd0;
    logic [2:0]  f3_0;
    logic [6:0]  f7_0;

    logic        in_ready1, out_valid1, rs1u1, rs2u1, rdwe1, ill1;
    logic [31:0] pc1, imm1;
    logic [10:0] cls1;
    logic [4:0]  rs1_1, rs2_1, rd1;
    logic [2:0]  f3_1;
    logic [6:0]  f7_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.PC_W(32), .RV32E(1'b0), .FENCE_LEGAL(1'b1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pc(pc0),
        .out_class(cls0), .out_rs1(rs1_0), .out_rs2(rs2_0), .out_rd(rd0),
        .out_funct3(f3_0), .out_funct7(f7_0), .out_imm(imm0),
        .out_rs1_used(rs1u0), .out_rs2_used(rs2u0), .out_rd_we(rdwe0),
        .out_illegal(ill0)
    );

    decode_stage #(.PC_W(32), .RV32E(1'b1), .FENCE_LEGAL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pc(pc1),
        .out_class(cls1), .out_rs1(rs1_1), .out_rs2(rs2_1), .out_rd(rd1),
        .out_funct3(f3_1), .out_funct7(f7_1), .out_imm(imm1),
        .out_rs1_used(rs1u1), .out_rs2_used(rs2u1), .out_rd_we(rdwe1),
        .out_illegal(ill1)
    );

    // Whole visible output bundle, used for both the model and the DUTs.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [10:0] cls;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        rs1u;
        logic        rs2u;
        logic        rdwe;
        logic        ill;
    } dec_t;

    dec_t act0, act1, exp0, exp1;
    bit   model_known = 1'b0;

    assign act0 = {out_valid0, pc0, cls0, rs1_0, rs2_0, rd0, f3_0, f7_0,
                   imm0, rs1u0, rs2u0, rdwe0, ill0};
    assign act1 = {out_valid1, pc1, cls1, rs1_1, rs2_1, rd1, f3_1, f7_1,
                   imm1, rs1u1, rs2u1, rdwe1, ill1};

    // Behavioural decode: identifies the instruction kind by index
    // (0 = ALUREG ... 10 = FENCE), applies the legality rules and builds
    // the immediate with signed arithmetic.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input bit rv32e, input bit fence_ok);
        dec_t d;
        int   kind, f3, f7, rs1, rs2, rd, sx, sgn, imm;
        bit   legal, u1, u2, we;
        d    = '0;
        f3   = int'(ins[14:12]);
        f7   = int'(ins[31:25]);
        rs1  = int'(ins[19:15]);
        rs2  = int'(ins[24:20]);
        rd   = int'(ins[11:7]);
        case (ins[6:0])
            7'h33: kind = 0;
            7'h13: kind = 1;
            7'h63: kind = 2;
            7'h67: kind = 3;
            7'h6F: kind = 4;
            7'h17: kind = 5;
            7'h37: kind = 6;
            7'h03: kind = 7;
            7'h23: kind = 8;
            7'h73: kind = 9;
            7'h0F: kind = fence_ok ? 10 : -1;
            default: kind = -1;
        endcase
        legal = (ins[1:0] == 2'b11) && (kind >= 0);
        if (kind == 0 && !(f7 == 0 || f7 == 32)) legal = 0;
        if (kind == 0 && f7 == 32 && !(f3 == 0 || f3 == 5)) legal = 0;
        if (kind == 1 && f3 == 1 && f7 != 0) legal = 0;
        if (kind == 1 && f3 == 5 && !(f7 == 0 || f7 == 32)) legal = 0;
        if (kind == 2 && (f3 == 2 || f3 == 3)) legal = 0;
        if (kind == 3 && f3 != 0) legal = 0;
        if (kind == 7 && (f3 == 3 || f3 >= 6)) legal = 0;
        if (kind == 8 && f3 >= 3) legal = 0;
        u1 = kind inside {0, 1, 2, 3, 7, 8};
        u2 = kind inside {0, 2, 8};
        we = ((kind inside {0, 1, 3, 4, 5, 6, 7}) || (kind == 9 && f3 != 0)) && rd != 0;
        if (rv32e && ((u1 && rs1 >= 16) || (u2 && rs2 >= 16) || (we && rd >= 16)))
            legal = 0;

        sx  = int'(ins);
        sgn = sx >>> 31;
        imm = 0;
        if (legal) begin
            if (kind inside {1, 3, 7, 9, 10}) imm = sx >>> 20;
            else if (kind == 8) begin
                imm = sx >>> 25;
                imm = imm * 32 + int'(ins[11:7]);
            end
            else if (kind == 2)
                imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2;
            else if (kind == 5 || kind == 6) imm = int'(ins & 32'hFFFFF000);
            else if (kind == 4)
                imm = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
        end

        d.valid = 1'b1;
        d.pc    = pc;
        d.rs1   = ins[19:15];
        d.rs2   = ins[24:20];
        d.rd    = ins[11:7];
        d.f3    = ins[14:12];
        d.f7    = ins[31:25];
        d.imm   = imm;
        d.ill   = !legal;
        if (legal) begin
            d.cls  = 11'(1 << kind);
            d.rs1u = u1;
            d.rs2u = u2;
            d.rdwe = we;
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        check("bundle_rv32i", 128'(act0), 128'(exp0));
        check("bundle_rv32e", 128'(act1), 128'(exp1));
    endtask

    // One clock of stimulus: drive inputs, check ready before the edge,
    // advance the model at the edge, then compare outputs just after it.
    task automatic applyStimulus(input bit rst, input bit iv, input logic [31:0] ins,
                                 input logic [31:0] pc, input bit fl, input bit ordy);
        bit take;
        reset     = rst;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        #1;
        if (model_known) begin
            check("in_ready_rv32i", 128'(in_ready0), 128'(!exp0.valid || ordy));
            check("in_ready_rv32e", 128'(in_ready1), 128'(!exp1.valid || ordy));
        end
        take = iv && (!exp0.valid || ordy) && !fl;
        @(posedge clk);
        if (rst) begin
            exp0 = '0;
            exp1 = '0;
            model_known = 1'b1;
        end else if (fl) begin
            exp0.valid = 1'b0;
            exp1.valid = 1'b0;
        end else if (take) begin
            exp0 = ref_decode(ins, pc, 1'b0, 1'b1);
            exp1 = ref_decode(ins, pc, 1'b1, 1'b0);
        end else if (ordy) begin
            exp0.valid = 1'b0;
            exp1.valid = 1'b0;
        end
        #1;
        if (model_known) checkOutput();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [10:0] cls;
        logic [31:0] imm;
        logic [4:0]  rd;
        bit          rdwe;
        bit          rs1u;
        bit          rs2u;
        bit          ill;
        bit          ill_e;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] r, ins;
        int          sel;
        logic [6:0]  ops[11];

        vecs = '{
            '{32'hFFF00093, 11'h002, 32'hFFFFFFFF, 5'd1,  1, 1, 0, 0, 0},
            '{32'h0020A423, 11'h100, 32'h00000008, 5'd8,  0, 1, 1, 0, 0},
            '{32'hFE000EE3, 11'h004, 32'hFFFFFFFC, 5'd29, 0, 1, 1, 0, 0},
            '{32'h00000000, 11'h000, 32'h00000000, 5'd0,  0, 0, 0, 1, 1},
            '{32'h4000F033, 11'h000, 32'h00000000, 5'd0,  0, 0, 0, 1, 1},
            '{32'h0000B003, 11'h000, 32'h00000000, 5'd0,  0, 0, 0, 1, 1},
            '{32'h00208833, 11'h001, 32'h00000000, 5'd16, 1, 1, 1, 0, 1},
            '{32'h123452B7, 11'h040, 32'h12345000, 5'd5,  1, 0, 0, 0, 0},
            '{32'h0080006F, 11'h010, 32'h00000008, 5'd0,  0, 0, 0, 0, 0},
            '{32'h0FF0000F, 11'h400, 32'h000000FF, 5'd0,  0, 0, 0, 0, 1},
            '{32'hC00021F3, 11'h200, 32'hFFFFFC00, 5'd3,  1, 0, 0, 0, 0},
            '{32'hFFFFF397, 11'h020, 32'hFFFFF000, 5'd7,  1, 0, 0, 0, 0},
            '{32'h4030D093, 11'h002, 32'h00000403, 5'd1,  1, 1, 0, 0, 0},
            '{32'h40309093, 11'h000, 32'h00000000, 5'd1,  0, 0, 0, 1, 1},
            '{32'h00001067, 11'h000, 32'h00000000, 5'd0,  0, 0, 0, 1, 1},
            '{32'hFFC12503, 11'h080, 32'hFFFFFFFC, 5'd10, 1, 1, 0, 0, 0},
            '{32'h0020B423, 11'h000, 32'h00000000, 5'd8,  0, 0, 0, 1, 1}
        };
        ops = '{7'h33, 7'h13, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37,
                7'h03, 7'h23, 7'h73, 7'h0F};

        // Reset state: everything zero and ready high once reset is seen.
        applyStimulus(1, 0, 32'h0, 32'h0, 0, 0);
        applyStimulus(1, 1, 32'hFFF00093, 32'h40, 0, 0);
        check("reset_bundle", 128'(act0), 128'd0);
        check("reset_in_ready", 128'(in_ready0), 128'd1);

        // Directed table, issued back to back with out_ready high.
        foreach (vecs[i]) begin
            applyStimulus(0, 1, vecs[i].instr, 32'h1000 + 32'(i * 4), 0, 1);
            check($sformatf("vec%0d_valid", i), 128'(out_valid0), 128'd1);
            check($sformatf("vec%0d_pc", i), 128'(pc0), 128'(32'h1000 + 32'(i * 4)));
            check($sformatf("vec%0d_class", i), 128'(cls0), 128'(vecs[i].cls));
            check($sformatf("vec%0d_imm", i), 128'(imm0), 128'(vecs[i].imm));
            check($sformatf("vec%0d_rd", i), 128'(rd0), 128'(vecs[i].rd));
            check($sformatf("vec%0d_flags", i), 128'({rdwe0, rs1u0, rs2u0, ill0}),
                  128'({vecs[i].rdwe, vecs[i].rs1u, vecs[i].rs2u, vecs[i].ill}));
            check($sformatf("vec%0d_ill_e", i), 128'(ill1), 128'(vecs[i].ill_e));
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
        check("drain_valid", 128'(out_valid0), 128'd0);

        // Backpressure: A held for three cycles while B is offered.
        applyStimulus(0, 1, 32'hFFF00093, 32'h200, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 32'h0020A423, 32'h204, 0, 0);
            check("bp_in_ready", 128'(in_ready0), 128'd0);
            check("bp_pc", 128'(pc0), 128'(32'h200));
            check("bp_imm", 128'(imm0), 128'(32'hFFFFFFFF));
        end
        applyStimulus(0, 1, 32'h0020A423, 32'h204, 0, 1);
        check("bp_release_pc", 128'(pc0), 128'(32'h204));
        check("bp_release_imm", 128'(imm0), 128'(32'h8));
        check("bp_release_valid", 128'(out_valid0), 128'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 1);
        check("bp_no_dup", 128'(out_valid0), 128'd0);

        // Flush while a bundle is held and another is offered.
        applyStimulus(0, 1, 32'h123452B7, 32'h300, 0, 0);
        applyStimulus(0, 1, 32'hFFFFF397, 32'h304, 1, 0);
        check("flush_valid", 128'(out_valid0), 128'd0);
        check("flush_pc_kept", 128'(pc0), 128'(32'h300));
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0);

        // Reset in the middle of backpressure overrides flush and accept.
        applyStimulus(0, 1, 32'hFFC12503, 32'h400, 0, 0);
        applyStimulus(0, 1, 32'h00208833, 32'h404, 0, 0);
        applyStimulus(1, 1, 32'h00208833, 32'h404, 1, 0);
        check("midreset_bundle", 128'(act0), 128'd0);
        check("midreset_in_ready", 128'(in_ready0), 128'd1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(3));
            r   = $urandom;
            if (sel == 0) ins = r;
            else ins = {r[31:7], ops[$urandom_range(10)]};
            applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 75, ins,
                          $urandom, $urandom_range(99) < 5, $urandom_range(99) < 70);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
